mac_stream: RTL and testbench

Parametrised, pipelined multiply-accumulate engine for streamed dot products.
- Accepts operand pairs on a valid/ready input stream.
- Accumulates their products over a frame delimited by first/last flags.
- Emits one accumulated result per frame on a valid/ready output stream.
- Sits between operand buffers and the post-processing/scaling logic in the arithmetic datapath.

---
 rtl/mac_pkg.sv | 29 ++
 rtl/mac_mult_stage.sv | 60 ++++++
 rtl/mac_stream.sv | 121 ++++++++++++
 tb/tb_mac_stream.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types, constants and saturation helpers for the mac_stream engine.
package mac_pkg;

    localparam int PIPE_LAT  = 3;
    localparam int SAT_MAX_W = 256;

    typedef struct packed {
        logic first;
        logic last;
    } frame_flags_t;

    // Both helpers return a SAT_MAX_W-wide word; callers keep the low accW bits.
    function automatic logic [SAT_MAX_W-1:0] sat_max(input int accW, input bit isSigned);
        logic [SAT_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < SAT_MAX_W; i++) begin
            if (i < accW - (isSigned ? 1 : 0)) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [SAT_MAX_W-1:0] sat_min(input int accW, input bit isSigned);
        logic [SAT_MAX_W-1:0] v;
        v = '0;
        if (isSigned) v[accW-1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// S1 operand register and S2 registered multiplier of mac_stream, with the
// valid/first/last sideband travelling alongside the data.
module mac_mult_stage
    import mac_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SIGNED = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en_i,
    input  logic                valid_i,
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
    input  frame_flags_t        flags_i,
    output logic                s1_valid_o,
    output logic                s2_valid_o,
    output frame_flags_t        s2_flags_o,
    output logic [2*DATA_W-1:0] prod_o
);

    logic [DATA_W-1:0]   a_q, b_q;
    logic                s1Valid_q, s2Valid_q;
    frame_flags_t        s1Flags_q, s2Flags_q;
    logic [2*DATA_W-1:0] prod_d, prod_q;

    // Widening both operands first keeps the low 2*DATA_W bits of the product exact.
    always_comb begin
        if (SIGNED != 0)
            prod_d = {{DATA_W{a_q[DATA_W-1]}}, a_q} * {{DATA_W{b_q[DATA_W-1]}}, b_q};
        else
            prod_d = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q       <= '0;
            b_q       <= '0;
            s1Valid_q <= 1'b0;
            s1Flags_q <= '0;
            s2Valid_q <= 1'b0;
            s2Flags_q <= '0;
            prod_q    <= '0;
        end else if (en_i) begin
            a_q       <= a_i;
            b_q       <= b_i;
            s1Valid_q <= valid_i;
            s1Flags_q <= flags_i;
            s2Valid_q <= s1Valid_q;
            s2Flags_q <= s1Flags_q;
            prod_q    <= prod_d;
        end
    end

    assign s1_valid_o = s1Valid_q;
    assign s2_valid_o = s2Valid_q;
    assign s2_flags_o = s2Flags_q;
    assign prod_o     = prod_q;

endmodule

// File: rtl/mac_stream.sv
// Pipelined streaming multiply-accumulate: one result per first/last frame.
// Define MAC_STREAM_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module mac_stream
    import mac_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 72,
    parameter int SIGNED = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_first,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_ovf,
    output logic              busy
);

    logic                adv;
    frame_flags_t        inFlags, s2Flags;
    logic                s1Valid, s2Valid;
    logic [2*DATA_W-1:0] prod;

    logic [ACC_W-1:0]    acc_q, acc_d, out_acc_q;
    logic                ovf_q, ovf_d, out_ovf_q, out_valid_q;
    logic [ACC_W-1:0]    extProd, accBase, accSum;
    logic                carry, beatOvf, ovfPrev;

`ifdef MAC_STREAM_SAT_EN
    localparam logic [SAT_MAX_W-1:0] SAT_MAX_FULL = sat_max(ACC_W, SIGNED != 0);
    localparam logic [SAT_MAX_W-1:0] SAT_MIN_FULL = sat_min(ACC_W, SIGNED != 0);
    localparam logic [ACC_W-1:0]     SAT_MAX      = SAT_MAX_FULL[ACC_W-1:0];
    localparam logic [ACC_W-1:0]     SAT_MIN      = SAT_MIN_FULL[ACC_W-1:0];
`endif

    // The whole pipeline freezes while a result waits for the consumer.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv && !reset;
    assign inFlags  = '{first: in_first, last: in_last};

    mac_mult_stage #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
    ) u_mult (
        .clk        (clk),
        .reset      (reset),
        .en_i       (adv),
        .valid_i    (in_valid),
        .a_i        (in_a),
        .b_i        (in_b),
        .flags_i    (inFlags),
        .s1_valid_o (s1Valid),
        .s2_valid_o (s2Valid),
        .s2_flags_o (s2Flags),
        .prod_o     (prod)
    );

    always_comb begin
        if (SIGNED != 0)
            extProd = ACC_W'($signed(prod));
        else
            extProd = ACC_W'(prod);
        accBase          = s2Flags.first ? '0 : acc_q;
        {carry, accSum}  = {1'b0, accBase} + {1'b0, extProd};
        if (SIGNED != 0)
            beatOvf = (accBase[ACC_W-1] == extProd[ACC_W-1]) &&
                      (accSum[ACC_W-1] != accBase[ACC_W-1]);
        else
            beatOvf = carry;
        ovfPrev = s2Flags.first ? 1'b0 : ovf_q;
        ovf_d   = ovfPrev | beatOvf;
`ifdef MAC_STREAM_SAT_EN
        // Once clamped the accumulator holds its limit until the frame ends.
        if (ovfPrev)
            acc_d = acc_q;
        else if (beatOvf)
            acc_d = ((SIGNED != 0) && accBase[ACC_W-1]) ? SAT_MIN : SAT_MAX;
        else
            acc_d = accSum;
`else
        acc_d = accSum;
`endif
    end

    // A new result may load in the same cycle the previous one is consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_acc_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (out_valid_q && out_ready) out_valid_q <= 1'b0;
            if (adv && s2Valid) begin
                if (s2Flags.last) begin
                    out_acc_q   <= acc_d;
                    out_ovf_q   <= ovf_d;
                    out_valid_q <= 1'b1;
                    acc_q       <= '0;
                    ovf_q       <= 1'b0;
                end else begin
                    acc_q <= acc_d;
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_ovf   = out_ovf_q;
    assign busy      = s1Valid || s2Valid || out_valid_q;

endmodule

// File: tb/tb_mac_stream.sv
// Directed bench for mac_stream: an unsigned (8x8, 20-bit) and a signed (8x8, 16-bit)
// instance share one input stream and are checked against hand-computed results.
module tb_mac_stream;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_first, in_last, out_ready;
    logic [7:0] in_a, in_b;

    logic        uReady, uValid, uOvf, uBusy;
    logic        sReady, sValid, sOvf, sBusy;
    logic [19:0] uAcc;
    logic [15:0] sAcc;

    int assertCount = 0;
    int failCount   = 0;

    logic [7:0]  bbA [6];
    logic [7:0]  bbB [6];
    logic [31:0] uExpB [6];
    logic [31:0] sExpB [6];
    logic [31:0] sOvfExp;

    always #5 clk = ~clk;

    mac_stream #(.DATA_W(8), .ACC_W(20), .SIGNED(0)) u_uns (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(uReady),
        .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
        .out_valid(uValid), .out_ready(out_ready),
        .out_acc(uAcc), .out_ovf(uOvf), .busy(uBusy)
    );

    mac_stream #(.DATA_W(8), .ACC_W(16), .SIGNED(1)) u_sgn (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(sReady),
        .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
        .out_valid(sValid), .out_ready(out_ready),
        .out_acc(sAcc), .out_ovf(sOvf), .busy(sBusy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkFlag(input string tag, input logic observed, input logic expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %b, expected %b", tag, observed, expected);
        end
    endtask

    task automatic checkResult(input string tag, input logic [31:0] uExp, input logic uOvfE,
                               input logic [31:0] sExp, input logic sOvfE);
        checkFlag({tag, " u valid"}, uValid, 1'b1);
        checkOutput({tag, " u acc"}, 32'(uAcc), uExp);
        checkFlag({tag, " u ovf"}, uOvf, uOvfE);
        checkFlag({tag, " s valid"}, sValid, 1'b1);
        checkOutput({tag, " s acc"}, 32'(sAcc), sExp);
        checkFlag({tag, " s ovf"}, sOvf, sOvfE);
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic first, input logic last);
        int waitCycles = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_first = first;
        in_last  = last;
        while (!uReady && waitCycles < 20) begin
            tick();
            waitCycles++;
        end
        if (!uReady) begin
            failCount++;
            $error("[TB] FAIL ready timeout: in_ready observed 0, expected 1");
        end
        tick();
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic waitResult();
        int waitCycles = 0;
        while (!uValid && waitCycles < 20) begin
            tick();
            waitCycles++;
        end
        if (!uValid) begin
            failCount++;
            $error("[TB] FAIL result timeout: out_valid observed 0, expected 1");
        end
    endtask

    initial begin
        bbA   = '{8'd1, 8'd2, 8'd4, 8'd6, 8'd15, 8'hFD};
        bbB   = '{8'd1, 8'd3, 8'd5, 8'd7, 8'd15, 8'd5};
        uExpB = '{32'd1, 32'd6, 32'd20, 32'd42, 32'd225, 32'd1265};
        sExpB = '{32'd1, 32'd6, 32'd20, 32'd42, 32'd225, 32'h0000FFF1};
`ifdef MAC_STREAM_SAT_EN
        sOvfExp = 32'h00007FFF;
`else
        sOvfExp = 32'h0000FC04;
`endif

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        checkFlag("reset u in_ready", uReady, 1'b0);
        checkFlag("reset s in_ready", sReady, 1'b0);
        checkFlag("reset u out_valid", uValid, 1'b0);
        checkOutput("reset u out_acc", 32'(uAcc), 32'd0);
        checkFlag("reset u out_ovf", uOvf, 1'b0);
        checkFlag("reset u busy", uBusy, 1'b0);
        checkFlag("reset s out_valid", sValid, 1'b0);
        checkOutput("reset s out_acc", 32'(sAcc), 32'd0);
        reset = 1'b0;
        #1;
        checkFlag("post-reset u in_ready", uReady, 1'b1);
        checkFlag("post-reset s in_ready", sReady, 1'b1);

        $display("[TB] basic frame and latency");
        out_ready = 1'b1;
        applyStimulus(8'd3, 8'd4, 1'b1, 1'b0);
        applyStimulus(8'd5, 8'd6, 1'b0, 1'b0);
        applyStimulus(8'd7, 8'd8, 1'b0, 1'b1);
        checkFlag("latency cycle1", uValid, 1'b0);
        tick();
        checkFlag("latency cycle2", uValid, 1'b0);
        tick();
        checkResult("frame98", 32'd98, 1'b0, 32'd98, 1'b0);
        checkFlag("frame98 busy", uBusy, 1'b1);
        tick();
        checkFlag("frame98 consumed", uValid, 1'b0);
        checkFlag("idle busy", uBusy, 1'b0);

        $display("[TB] backpressure with three frames");
        out_ready = 1'b0;
        applyStimulus(8'd3, 8'd4, 1'b1, 1'b0);
        applyStimulus(8'd5, 8'd6, 1'b0, 1'b0);
        applyStimulus(8'd7, 8'd8, 1'b0, 1'b1);
        applyStimulus(8'h80, 8'h80, 1'b1, 1'b0);
        applyStimulus(8'h7F, 8'hFF, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_a     = 8'hFE;
        in_b     = 8'd3;
        in_first = 1'b1;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkFlag($sformatf("stall%0d u in_ready", i), uReady, 1'b0);
            checkFlag($sformatf("stall%0d s in_ready", i), sReady, 1'b0);
            checkResult($sformatf("stall%0d", i), 32'd98, 1'b0, 32'd98, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        checkFlag("release in_ready", uReady, 1'b1);
        tick();
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        waitResult();
        checkResult("frame2", 32'd48769, 1'b0, 32'd16257, 1'b0);
        tick();
        waitResult();
        checkResult("frame3", 32'd762, 1'b0, 32'h0000FFFA, 1'b0);
        tick();
        checkFlag("after frame3", uValid, 1'b0);

        $display("[TB] overflow frame");
        for (int i = 0; i < 4; i++)
            applyStimulus(8'd127, 8'd127, i == 0, i == 3);
        waitResult();
        checkResult("overflow", 32'd64516, 1'b0, sOvfExp, 1'b1);
        tick();

        $display("[TB] reset mid-frame");
        applyStimulus(8'd5, 8'd5, 1'b1, 1'b0);
        applyStimulus(8'd6, 8'd6, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        checkFlag("mid reset in_ready", uReady, 1'b0);
        tick();
        checkFlag("mid reset out_valid", uValid, 1'b0);
        checkFlag("mid reset busy", sBusy, 1'b0);
        reset = 1'b0;
        applyStimulus(8'd2, 8'd3, 1'b1, 1'b1);
        waitResult();
        checkResult("post reset", 32'd6, 1'b0, 32'd6, 1'b0);
        tick();
        tick();
        tick();
        checkFlag("no stale result", uValid, 1'b0);

        $display("[TB] back-to-back single-beat frames");
        for (int k = 0; k < 8; k++) begin
            if (k < 6) begin
                in_valid = 1'b1;
                in_a     = bbA[k];
                in_b     = bbB[k];
                in_first = 1'b1;
                in_last  = 1'b1;
            end else begin
                in_valid = 1'b0;
                in_first = 1'b0;
                in_last  = 1'b0;
            end
            tick();
            if (k >= 2)
                checkResult($sformatf("b2b%0d", k - 2), uExpB[k-2], 1'b0, sExpB[k-2], 1'b0);
        end
        tick();
        checkFlag("b2b drained", uValid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
